// File: rtl/acc_pkg.sv
// Shared op codes and types for the accumulator bank.
// ACC_SATURATE_EN (optional macro) selects saturating INC/DEC in acc_slice.
package acc_pkg;

  typedef logic [2:0] acc_op_t;

  localparam acc_op_t ACC_NOP  = 3'd0;
  localparam acc_op_t ACC_LOAD = 3'd1;
  localparam acc_op_t ACC_CLR  = 3'd2;
  localparam acc_op_t ACC_INC  = 3'd3;
  localparam acc_op_t ACC_DEC  = 3'd4;
  localparam acc_op_t ACC_SHL  = 3'd5;
  localparam acc_op_t ACC_SHR  = 3'd6;
  localparam acc_op_t ACC_ROLC = 3'd7;

endpackage

// File: rtl/acc_slice.sv
// One accumulator with its carry bit, executing an in-place op when exec is high.
// ACC_SATURATE_EN defined: INC/DEC clamp at all-ones/zero instead of wrapping.
module acc_slice
  import acc_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             exec,
  input  acc_op_t          op,
  input  logic [WIDTH-1:0] bus_in,
  output logic [WIDTH-1:0] value,
  output logic             carry
);

  localparam logic [WIDTH-1:0] ONES = '1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value <= '0;
      carry <= 1'b0;
    end else if (exec) begin
      case (op)
        ACC_NOP: ;
        ACC_LOAD: begin
          value <= bus_in;
          carry <= 1'b0;
        end
        ACC_CLR: begin
          value <= '0;
          carry <= 1'b0;
        end
        ACC_INC: begin
`ifdef ACC_SATURATE_EN
          if (value == ONES) begin
            carry <= 1'b1;
          end else begin
            value <= value + 1'b1;
            carry <= 1'b0;
          end
`else
          {carry, value} <= {1'b0, value} + 1'b1;
`endif
        end
        ACC_DEC: begin
`ifdef ACC_SATURATE_EN
          if (value == '0) begin
            carry <= 1'b1;
          end else begin
            value <= value - 1'b1;
            carry <= 1'b0;
          end
`else
          value <= value - 1'b1;
          carry <= (value == '0);
`endif
        end
        ACC_SHL: begin
          value <= {value[WIDTH-2:0], 1'b0};
          carry <= value[WIDTH-1];
        end
        ACC_SHR: begin
          value <= {1'b0, value[WIDTH-1:1]};
          carry <= value[0];
        end
        ACC_ROLC: begin
          // Old carry enters at the LSB while the MSB moves into carry.
          value <= {value[WIDTH-2:0], carry};
          carry <= value[WIDTH-1];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/accumulator_bank.sv
// Bank of NUM_ACC accumulator slices with an AccSel-muxed ALU view and a registered bus output.
// ACC_SATURATE_EN (optional macro, see acc_slice) selects saturating INC/DEC.
module accumulator_bank
  import acc_pkg::*;
#(
  parameter  int WIDTH   = 4,
  parameter  int NUM_ACC = 2,
  localparam int SEL_W   = (NUM_ACC > 1) ? $clog2(NUM_ACC) : 1
) (
  input  logic             MainClock,
  input  logic             ClearN,
  input  logic [SEL_W-1:0] AccSel,
  input  logic [2:0]       Op,
  input  logic             OpValid,
  input  logic [WIDTH-1:0] BusIn,
  input  logic             EnableOut,
  output logic [WIDTH-1:0] BusOut,
  output logic             BusOutEn,
  output logic [WIDTH-1:0] AluOut,
  output logic             Carry,
  output logic             Zero
);

  logic [WIDTH-1:0] acc_val [NUM_ACC];
  logic [NUM_ACC-1:0] acc_carry;

  for (genvar i = 0; i < NUM_ACC; i++) begin : g_slice
    acc_slice #(.WIDTH(WIDTH)) u_slice (
      .clk    (MainClock),
      .rst_n  (ClearN),
      .exec   (OpValid && (AccSel == SEL_W'(i))),
      .op     (acc_op_t'(Op)),
      .bus_in (BusIn),
      .value  (acc_val[i]),
      .carry  (acc_carry[i])
    );
  end

  // An AccSel beyond the bank matches no slice, so the view reads zero.
  always_comb begin
    AluOut = '0;
    Carry  = 1'b0;
    for (int i = 0; i < NUM_ACC; i++) begin
      if (AccSel == SEL_W'(i)) begin
        AluOut = acc_val[i];
        Carry  = acc_carry[i];
      end
    end
  end

  assign Zero = (AluOut == '0);

  // Bus register captures the pre-update value; tri-stating happens above this block.
  always_ff @(posedge MainClock or negedge ClearN) begin
    if (!ClearN) begin
      BusOut   <= '0;
      BusOutEn <= 1'b0;
    end else begin
      BusOutEn <= EnableOut;
      BusOut   <= EnableOut ? AluOut : '0;
    end
  end

endmodule
